// File: rtl/zone_gray_buf_pkg.sv
// zone_gray_buf_pkg: shared constants for the zone brightness path.
// Holds the write-mode encodings and the default zone count / gray width
// used by the statistics stage, this buffer and the LED driver.
package zone_gray_buf_pkg;

  localparam int unsigned ZONES_DEF  = 360;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic WR_OVERWRITE = 1'b0;
  localparam logic WR_MAX       = 1'b1;

endpackage

// File: rtl/zone_bank.sv
// zone_bank: one bank of zone storage with a per-zone valid vector.
// Ports:
//   clk          clock
//   clr          synchronous clear of the whole valid vector (memory kept)
//   we/waddr     write strobe and zone index (out-of-range index ignored)
//   wdata/wmode  write value and mode (overwrite or unsigned max-merge)
//   raddr        combinational read index
//   rdata_c      stored value masked by valid; 0 for invalid/out-of-range
//   all_valid_c  every zone of this bank written since the last clear
module zone_bank
  import zone_gray_buf_pkg::*;
#(
  parameter int unsigned ZONES  = ZONES_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned AW     = $clog2(ZONES)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wmode,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata_c,
  output logic              all_valid_c
);

  logic [DATA_W-1:0] mem_q [ZONES];
  logic [DATA_W-1:0] mem_d;
  logic              mem_we;
  logic [ZONES-1:0]  valid_q;
  logic [ZONES-1:0]  valid_d;
  logic [DATA_W-1:0] stored;
  logic              w_in;
  logic              r_in;

  // Write path: merge reads the live array, so consecutive merges chain.
  always_comb begin
    w_in   = 32'(waddr) < ZONES;
    mem_we = we && w_in;
    stored = '0;
    if (w_in && valid_q[waddr]) stored = mem_q[waddr];
    mem_d = wdata;
    case (wmode)
      WR_OVERWRITE: mem_d = wdata;
      WR_MAX:       if (stored > wdata) mem_d = stored;
    endcase
  end

  // Valid vector: clear dominates a write in the same cycle.
  always_comb begin
    valid_d = valid_q;
    if (clr) valid_d = '0;
    else if (mem_we) valid_d[waddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
  end

  // Storage is never reset; the valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[waddr] <= mem_d;
  end

  // Masked read port.
  always_comb begin
    r_in    = 32'(raddr) < ZONES;
    rdata_c = '0;
    if (r_in && valid_q[raddr]) rdata_c = mem_q[raddr];
  end

  assign all_valid_c = &valid_q;

endmodule

// File: rtl/zone_gray_buf.sv
// zone_gray_buf: double-buffered zone brightness store.
// Ports:
//   clk_x1, rst          clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data/wr_mode  write into bank bank_sel
//   frame_done           swaps banks and clears the new write bank's valids
//   rd_en/rd_addr        read from bank ~bank_sel, 1-cycle latency
//   rd_data/rd_valid     registered read result
//   bank_sel             current write bank
//   frame_full           all zones of the write bank written this frame
module zone_gray_buf
  import zone_gray_buf_pkg::*;
#(
  parameter  int unsigned ZONES  = ZONES_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned AW     = $clog2(ZONES)
) (
  input  logic              clk_x1,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_mode,
  input  logic              frame_done,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              bank_sel,
  output logic              frame_full
);

  logic              bank_sel_q, bank_sel_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              we0, we1, clr0, clr1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              full0, full1;

  // Routing: the bank being opened for writing is the one cleared on a swap.
  always_comb begin
    we0  = wr_en && !bank_sel_q;
    we1  = wr_en &&  bank_sel_q;
    clr0 = rst || (frame_done &&  bank_sel_q);
    clr1 = rst || (frame_done && !bank_sel_q);
  end

  zone_bank #(.ZONES(ZONES), .DATA_W(DATA_W), .AW(AW)) u_bank0 (
    .clk         (clk_x1),
    .clr         (clr0),
    .we          (we0),
    .waddr       (wr_addr),
    .wdata       (wr_data),
    .wmode       (wr_mode),
    .raddr       (rd_addr),
    .rdata_c     (rdata0),
    .all_valid_c (full0)
  );

  zone_bank #(.ZONES(ZONES), .DATA_W(DATA_W), .AW(AW)) u_bank1 (
    .clk         (clk_x1),
    .clr         (clr1),
    .we          (we1),
    .waddr       (wr_addr),
    .wdata       (wr_data),
    .wmode       (wr_mode),
    .raddr       (rd_addr),
    .rdata_c     (rdata1),
    .all_valid_c (full1)
  );

  // Next state: read uses the pre-swap read bank when frame_done coincides.
  always_comb begin
    bank_sel_d = bank_sel_q;
    rd_valid_d = rd_en;
    rd_data_d  = '0;
    if (frame_done) bank_sel_d = !bank_sel_q;
    if (rd_en) rd_data_d = bank_sel_q ? rdata0 : rdata1;
  end

  always_ff @(posedge clk_x1) begin
    if (rst) begin
      bank_sel_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      bank_sel_q <= bank_sel_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bank_sel   = bank_sel_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign frame_full = bank_sel_q ? full1 : full0;

endmodule

// File: tb/tb_zone_gray_buf.sv
module tb_zone_gray_buf;

  localparam int unsigned ZONES  = 360;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned AW     = 9;

  logic              clk_x1 = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_mode;
  logic              frame_done;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              bank_sel;
  logic              frame_full;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  zone_gray_buf #(.ZONES(ZONES), .DATA_W(DATA_W)) dut (
    .clk_x1     (clk_x1),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_mode    (wr_mode),
    .frame_done (frame_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .bank_sel   (bank_sel),
    .frame_full (frame_full)
  );

  always #5 clk_x1 = ~clk_x1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; inputs set before this are sampled at that edge.
  task automatic tick();
    @(posedge clk_x1);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mode = 1'b0;
    frame_done = 1'b0; rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic wr(input int unsigned a, input logic [7:0] d, input logic m);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_mode = m;
    tick();
    idle();
  endtask

  task automatic swap();
    frame_done = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd(input int unsigned a);
    rd_en = 1'b1; rd_addr = AW'(a);
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_frame_full", 32'(frame_full), 32'd0);

    // Basic write / swap / read
    wr(5, 8'h40, 1'b0);
    swap();
    rd(5);
    chk("basic_valid", 32'(rd_valid), 32'd1);
    chk("basic_data", 32'(rd_data), 32'h40);
    chk("basic_bank_sel", 32'(bank_sel), 32'd1);
    tick();
    chk("rd_idle_valid", 32'(rd_valid), 32'd0);
    chk("rd_idle_data", 32'(rd_data), 32'd0);

    // Max-merge then overwrite, consecutive cycles
    wr(10, 8'h30, 1'b1);
    wr(10, 8'h80, 1'b1);
    wr(10, 8'h20, 1'b1);
    swap();
    rd(10);
    chk("merge_data", 32'(rd_data), 32'h80);
    wr(10, 8'h30, 1'b0);
    wr(10, 8'h80, 1'b0);
    wr(10, 8'h20, 1'b0);
    swap();
    rd(10);
    chk("overwrite_data", 32'(rd_data), 32'h20);

    // Stale data masking across frames
    wr(7, 8'h77, 1'b0);
    swap();
    rd(7);
    chk("stale_frame_a", 32'(rd_data), 32'h77);
    swap();
    rd(7);
    chk("stale_frame_b", 32'(rd_data), 32'h00);
    swap();
    rd(7);
    chk("stale_masked", 32'(rd_data), 32'h00);
    chk("stale_masked_valid", 32'(rd_valid), 32'd1);
    chk("stale_bank_sel", 32'(bank_sel), 32'd0);

    // Write coinciding with frame_done lands in the closing bank
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = 8'h11; frame_done = 1'b1;
    tick();
    idle();
    chk("same_wr_bank_sel", 32'(bank_sel), 32'd1);
    rd(3);
    chk("same_wr_data", 32'(rd_data), 32'h11);
    // Read coinciding with frame_done uses the pre-swap read bank
    rd_en = 1'b1; rd_addr = AW'(3); frame_done = 1'b1;
    tick();
    idle();
    chk("same_rd_data", 32'(rd_data), 32'h11);
    chk("same_rd_bank_sel", 32'(bank_sel), 32'd0);
    rd(3);
    chk("post_swap_rd", 32'(rd_data), 32'h00);

    // Fill every zone of bank 0
    for (int i = 0; i < int'(ZONES) - 1; i++) wr(i, 8'(i), 1'b0);
    chk("full_before_last", 32'(frame_full), 32'd0);
    wr(ZONES - 1, 8'(ZONES - 1), 1'b0);
    chk("full_after_last", 32'(frame_full), 32'd1);
    wr(ZONES, 8'hEE, 1'b0);
    chk("full_oor_write", 32'(frame_full), 32'd1);
    wr(511, 8'hEE, 1'b1);
    chk("full_oor_write_max", 32'(frame_full), 32'd1);
    swap();
    chk("full_dropped", 32'(frame_full), 32'd0);
    chk("full_bank_sel", 32'(bank_sel), 32'd1);
    rd(ZONES - 1);
    chk("last_zone_data", 32'(rd_data), 32'h67);
    rd(0);
    chk("zone0_data", 32'(rd_data), 32'h00);
    rd(200);
    chk("zone200_data", 32'(rd_data), 32'hC8);
    rd(ZONES);
    chk("oor_rd_valid", 32'(rd_valid), 32'd1);
    chk("oor_rd_data", 32'(rd_data), 32'h00);

    // Reset mid-frame with a read in flight
    for (int i = 0; i < 100; i++) wr(i, 8'hA5, 1'b0);
    rst = 1'b1; rd_en = 1'b1; rd_addr = AW'(200);
    tick();
    idle();
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    chk("midrst_bank_sel", 32'(bank_sel), 32'd0);
    chk("midrst_frame_full", 32'(frame_full), 32'd0);
    swap();
    rd(0);
    chk("midrst_rd0", 32'(rd_data), 32'h00);
    rd(50);
    chk("midrst_rd50", 32'(rd_data), 32'h00);
    rd(200);
    chk("midrst_rd200", 32'(rd_data), 32'h00);
    chk("midrst_rd200_valid", 32'(rd_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/zone_gray_buf.md
# zone_gray_buf

Parametrised, double-buffered zone brightness store for the local-dimming path. The statistics stage writes one gray value per backlight zone during frame N. The LED driver side reads the completed values of frame N-1 from the other bank. Adds configurable zone count and data width, ping-pong banking, per-zone valid tracking and a max-merge write mode, replacing the fixed 360-entry single-bank store.

## Interface
Parameters:
- ZONES, 360, number of backlight zones; legal addresses 0..ZONES-1
- DATA_W, 8, gray value width
- AW, clog2(ZONES), address width; derived, not overridden

Ports:
- clk_x1  in  1  pixel-rate clock; single clock domain
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe, one zone per cycle
- wr_addr  in  AW  zone index being written
- wr_data  in  DATA_W  gray value
- wr_mode  in  1  0 = overwrite, 1 = max-merge with stored value
- frame_done  in  1  one-cycle pulse; closes the write frame and swaps banks
- rd_en  in  1  read request
- rd_addr  in  AW  zone index to read
- rd_data  out  DATA_W  read result, registered
- rd_valid  out  1  rd_data qualifier, registered
- bank_sel  out  1  current write bank; the read bank is ~bank_sel
- frame_full  out  1  level; every zone in the write bank written this frame

## Operation
- Two banks. Each bank holds ZONES x DATA_W of storage and a ZONES-bit valid vector.
  - Writes always target bank bank_sel.
  - Reads always target bank ~bank_sel.
- Overwrite write: mem[a] <= wr_data; valid[a] <= 1.
- Max-merge write: mem[a] <= max(stored, wr_data), where stored is taken as 0 if valid[a] = 0; valid[a] <= 1.
  - The comparison is unsigned, DATA_W bits.
- wr_addr >= ZONES: write ignored; no state change.
- frame_done:
  - bank_sel toggles.
  - The valid vector of the new write bank is cleared in the same edge. Memory contents are not cleared; the valid bits mask them.
- Read result:
  - rd_data = mem[rd_addr] of the read bank if that zone's valid bit is set; otherwise 0.
  - rd_addr >= ZONES returns 0 with rd_valid = 1.
- rd_en low: the next cycle gives rd_valid = 0 and rd_data = 0.
- frame_full = AND of the write bank's valid vector. It drops to 0 on the cycle after frame_done.

## Timing
- Reset values:
  - bank_sel = 0, rd_data = 0, rd_valid = 0, frame_full = 0.
  - Both valid vectors cleared. Memory is not reset.
- Read latency is 1 cycle: the rd_en/rd_addr sampled at edge k appear as rd_valid/rd_data after edge k.
- Write commits at the sampling edge. It becomes readable only after the next frame_done; the minimum is 1 cycle after that pulse.
- Back-to-back max-merge writes to the same zone on consecutive cycles must merge correctly. The merge reads the current array value combinationally, so no forwarding hazard is allowed.
- wr_en and frame_done in the same cycle:
  - The write lands in the old write bank (the frame being closed).
  - The bank swaps on the same edge.
  - That value is readable from the next cycle.
- rd_en and frame_done in the same cycle: the read uses the pre-swap read bank.
- Reset asserted mid-frame:
  - All valid bits clear and bank_sel returns to 0.
  - An in-flight read returns rd_valid = 0 on the following cycle.
- A read and a write to the same zone index never conflict, because they always target different banks.

## Structure
- Package zone_gray_buf_pkg holds:
  - WR_OVERWRITE = 1'b0 and WR_MAX = 1'b1.
  - Default ZONES and DATA_W constants shared with the statistics and LED-driver blocks.
- Sub-module zone_bank (instantiated twice) contains:
  - the storage array and valid vector;
  - write/merge logic;
  - a synchronous valid clear;
  - a combinational masked read port;
  - an all_valid output.
- The top level holds:
  - the bank_sel register;
  - write/read routing by bank_sel;
  - the read output register;
  - the frame_full mux.

## Test plan
- Reset, write zone 5 = 0x40, then frame_done. The following cycle, read zone 5 → rd_valid = 1, rd_data = 0x40, bank_sel = 1.
- Max-merge to zone 10 with 0x30, 0x80, 0x20 on consecutive cycles, then swap and read → 0x80. Overwrite with the same sequence → 0x20.
- Two frames: write zone 7 only in frame A. In frame B write nothing, then swap. Read zone 7 → 0x00 (stale data masked).
- Same-cycle wr_en (zone 3 = 0x11) with frame_done. Next cycle read zone 3 → 0x11. Same-cycle rd_en with frame_done returns the pre-swap bank's value.
- Write all ZONES addresses → frame_full = 1 on the cycle after the last write; it drops the cycle after frame_done. Write to addr ZONES → ignored, and frame_full is unchanged.
- Assert rst mid-frame after 100 writes → bank_sel = 0, frame_full = 0. All reads after a swap return 0.
